// File: rtl/bound_flasher_pkg.sv
// Shared definitions for the bound_flasher LED path: the LED frame width used by
// both the pattern generator and the serializer, plus the serializer state codes.
package bound_flasher_pkg;

   // LED pattern width shared with bound_flasher
   localparam int LED_W = 16;

   // Serializer frame states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_LATCH = 2'd2;

endpackage

// File: rtl/led_ser_tick.sv
// CLK_DIV prescaler for the LED serializer. Emits a one-cycle tick every CLK_DIV
// enabled cycles; each tick marks the end of one sclk half-period. The count is
// restarted by reset or by a frame start so every frame has identical timing.
module led_ser_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int            DW       = $clog2(CLK_DIV) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt_q, div_cnt_d;

   // Next count: clear wins, otherwise advance and wrap at CLK_DIV-1 while enabled
   always_comb begin
      div_cnt_d = div_cnt_q;
      if (clr_i) begin
         div_cnt_d = '0;
      end else if (en_i) begin
         div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
      end
   end

   // Prescaler register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   assign tick_o = en_i & (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/led_shift_serializer.sv
// Serializes the parallel LED pattern into sclk/sdata/latch for a 74HC595-style
// shift-register chain. A frame goes out whenever the pattern differs from the last
// one sent (and once after reset). Changes arriving mid-frame are not queued; the
// compare simply re-runs on return to IDLE, so the newest value is always sent.
// Optional feature: define LED_SER_REFRESH_EN to periodically re-send the current
// pattern after REFRESH_PERIOD idle cycles.
module led_shift_serializer
   import bound_flasher_pkg::*;
#(
   parameter int WIDTH          = LED_W,
   parameter int CLK_DIV        = 4,
   parameter int MSB_FIRST      = 1,
   parameter int REFRESH_PERIOD = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] led_in,
   output logic             sclk,
   output logic             sdata,
   output logic             latch,
   output logic             busy
);

   localparam int            BW       = $clog2(WIDTH) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   logic [1:0]       state_q,     state_d;
   logic [WIDTH-1:0] shadow_q,    shadow_d;
   logic [WIDTH-1:0] sreg_q,      sreg_d;
   logic [BW-1:0]    bit_cnt_q,   bit_cnt_d;
   logic             init_pend_q, init_pend_d;
   logic             ld_pend_q,   ld_pend_d;
   logic             sclk_q,      sclk_d;
   logic             sdata_q,     sdata_d;
   logic             latch_q,     latch_d;
   logic             busy_q,      busy_d;

   logic [WIDTH-1:0] ord_in;
   logic             start;
   logic             refresh_hit;
   logic             tick;
   logic             tick_clr;
   logic             tick_en;

   // Present led_in in transmit order so the shifter always sends bit 0 first
   always_comb begin
      ord_in = led_in;
      if (MSB_FIRST != 0) begin
         for (int i = 0; i < WIDTH; i++) begin
            ord_in[i] = led_in[WIDTH-1-i];
         end
      end
   end

`ifdef LED_SER_REFRESH_EN
   localparam int            RW       = $clog2(REFRESH_PERIOD + 1);
   localparam logic [RW-1:0] RF_LAST  = RW'(REFRESH_PERIOD - 1);

   logic [RW-1:0] idle_cnt_q, idle_cnt_d;

   assign refresh_hit = (idle_cnt_q == RF_LAST);

   // Idle counter: counts IDLE cycles without a frame start, cleared by every start
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (state_q == ST_IDLE) begin
         idle_cnt_d = start ? '0 : idle_cnt_q + RW'(1);
      end
   end

   // Idle counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   // No periodic refresh; REFRESH_PERIOD has no effect in this build
   assign refresh_hit = 1'b0 && (REFRESH_PERIOD > 0);
`endif

   assign start = (state_q == ST_IDLE) &&
                  ((led_in != shadow_q) || init_pend_q || refresh_hit);

   // The prescaler is held during the one-cycle bit-0 load so the first sclk
   // rise lands CLK_DIV cycles after the first data bit is presented.
   assign tick_clr = start;
   assign tick_en  = ((state_q == ST_SHIFT) && !ld_pend_q) || (state_q == ST_LATCH);

   led_ser_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (tick_clr),
      .en_i   (tick_en),
      .tick_o (tick)
   );

   // Frame sequencer: capture in IDLE, clock bits out in SHIFT, strobe in LATCH
   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      sreg_d      = sreg_q;
      bit_cnt_d   = bit_cnt_q;
      init_pend_d = init_pend_q;
      ld_pend_d   = ld_pend_q;
      sclk_d      = sclk_q;
      sdata_d     = sdata_q;
      latch_d     = latch_q;
      busy_d      = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shadow_d    = led_in;
               sreg_d      = ord_in;
               init_pend_d = 1'b0;
               busy_d      = 1'b1;
               bit_cnt_d   = '0;
               ld_pend_d   = 1'b1;
               state_d     = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (ld_pend_q) begin
               // Present bit 0 with sclk low
               sdata_d   = sreg_q[0];
               sreg_d    = sreg_q >> 1;
               sclk_d    = 1'b0;
               ld_pend_d = 1'b0;
            end else if (tick) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bit_cnt_q == LAST_BIT) begin
                     // sdata keeps the last bit through the latch strobe
                     latch_d = 1'b1;
                     state_d = ST_LATCH;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BW'(1);
                     sdata_d   = sreg_q[0];
                     sreg_d    = sreg_q >> 1;
                  end
               end
            end
         end
         ST_LATCH: begin
            if (tick) begin
               latch_d = 1'b0;
               busy_d  = 1'b0;
               sdata_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers; reset aborts any frame without emitting a latch
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shadow_q    <= '0;
         sreg_q      <= '0;
         bit_cnt_q   <= '0;
         init_pend_q <= 1'b1;
         ld_pend_q   <= 1'b0;
         sclk_q      <= 1'b0;
         sdata_q     <= 1'b0;
         latch_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         sreg_q      <= sreg_d;
         bit_cnt_q   <= bit_cnt_d;
         init_pend_q <= init_pend_d;
         ld_pend_q   <= ld_pend_d;
         sclk_q      <= sclk_d;
         sdata_q     <= sdata_d;
         latch_q     <= latch_d;
         busy_q      <= busy_d;
      end
   end

   assign sclk  = sclk_q;
   assign sdata = sdata_q;
   assign latch = latch_q;
   assign busy  = busy_q;

endmodule
